// File: rtl/custom_unit_sequencer.sv
// Issue-path sequencer for the multi-cycle custom units: one request at a time,
// one-cycle start pulse, done/timeout wait, and a held response.
module custom_unit_sequencer #(
    parameter int NUM_UNITS      = 4,
    parameter int OP_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [OP_W-1:0]         req_op_i,
    input  logic [31:0]             req_rs0_i,
    input  logic [31:0]             req_rs1_i,
    input  logic [31:0]             req_rd_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_result_o,
    output logic                    rsp_err_o,
    output logic [NUM_UNITS-1:0]    unit_start_o,
    output logic [31:0]             unit_rs0_o,
    output logic [31:0]             unit_rs1_o,
    output logic [31:0]             unit_rd_o,
    input  logic [NUM_UNITS-1:0]    unit_done_i,
    input  logic [NUM_UNITS*32-1:0] unit_result_i,
    output logic                    busy_o
);

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [31:0]       rs0_q, rs1_q, rd_q;
    logic [31:0]       result_q, result_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              op_legal;
    logic              sel_done;
    logic [31:0]       sel_result;

    assign accept   = req_valid_i && (state_q == IDLE);
    assign op_legal = 32'(req_op_i) < 32'(NUM_UNITS);

    // Only the latched unit's done/result matter; other units are masked out.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (op_q == OP_W'(u)) begin
                sel_done   = unit_done_i[u];
                sel_result = unit_result_i[32*u +: 32];
            end
        end
    end

    always_comb begin
        unit_start_o = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_start_o[u] = (state_q == START) && (op_q == OP_W'(u));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    result_d = '0;
                    err_d    = !op_legal;
                    state_d  = op_legal ? START : RESP;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_done) begin
                    result_d = sel_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Operands stay put from one acceptance to the next.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q  <= '0;
            rs0_q <= '0;
            rs1_q <= '0;
            rd_q  <= '0;
        end else if (accept) begin
            op_q  <= req_op_i;
            rs0_q <= req_rs0_i;
            rs1_q <= req_rs1_i;
            rd_q  <= req_rd_i;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign rsp_result_o = result_q;
    assign rsp_err_o    = err_q;
    assign unit_rs0_o   = rs0_q;
    assign unit_rs1_o   = rs1_q;
    assign unit_rd_o    = rd_q;

endmodule

// File: tb/tb_custom_unit_sequencer.sv
// Bench for custom_unit_sequencer: per-transaction timeline model plus
// randomized traffic, noisy done lines, response stalls and a mid-op reset.
module tb_custom_unit_sequencer;

    localparam int NU = 3;
    localparam int OW = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [OW-1:0]   req_op = '0;
    logic [31:0]     req_rs0 = '0;
    logic [31:0]     req_rs1 = '0;
    logic [31:0]     req_rd = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_result;
    logic            rsp_err;
    logic [NU-1:0]   unit_start;
    logic [31:0]     unit_rs0, unit_rs1, unit_rd;
    logic [NU-1:0]   unit_done = '0;
    logic [NU*32-1:0] unit_result = '0;
    logic            busy;

    always #5 clk = ~clk;

    custom_unit_sequencer #(
        .NUM_UNITS(NU),
        .OP_W(OW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i(req_op),
        .req_rs0_i(req_rs0),
        .req_rs1_i(req_rs1),
        .req_rd_i(req_rd),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result),
        .rsp_err_o(rsp_err),
        .unit_start_o(unit_start),
        .unit_rs0_o(unit_rs0),
        .unit_rs1_o(unit_rs1),
        .unit_rd_o(unit_rd),
        .unit_done_i(unit_done),
        .unit_result_i(unit_result),
        .busy_o(busy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, written by the driver.
    logic            chk_en = 1'b0;
    logic            e_ready, e_valid, e_busy, e_err;
    logic [NU-1:0]   e_start;
    logic [31:0]     e_res, e_rs0, e_rs1, e_rd;
    int              cyc = 0;

    // Observations used by the hand-computed pins.
    int              obs_rc = -1;
    int              obs_start_cyc = -1;
    logic [31:0]     obs_res = '0;
    logic            obs_err = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("unit_start", 32'(unit_start), 32'(e_start));
            chk("unit_rs0", unit_rs0, e_rs0);
            chk("unit_rs1", unit_rs1, e_rs1);
            chk("unit_rd", unit_rd, e_rd);
            if (e_valid) begin
                chk("rsp_result", rsp_result, e_res);
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
            end
            if (rsp_valid && obs_rc < 0) begin
                obs_rc  = cyc;
                obs_res = rsp_result;
                obs_err = rsp_err;
            end
            if (unit_start != '0 && obs_start_cyc < 0) obs_start_cyc = cyc;
        end
    end

    logic [31:0] prev_rs0 = '0, prev_rs1 = '0, prev_rd = '0;

    // One transaction: cycle 0 is the accept cycle; done_cyc is when the
    // target unit pulses done; stall is how long the core holds off rsp_ready.
    task automatic run_txn(input logic [OW-1:0] op, input logic [31:0] rs0,
                           input logic [31:0] rs1, input logic [31:0] rd,
                           input int done_cyc, input int stall,
                           input logic noise, input logic [31:0] r_op);
        logic          legal;
        int            rc, hs;
        logic [31:0]   xr;
        logic          xe;
        logic [NU-1:0] oh;
        legal = 32'(op) < NU;
        oh = '0;
        if (legal) oh[op] = 1'b1;
        if (!legal) begin
            rc = 1; xr = '0; xe = 1'b1;
        end else if (done_cyc >= 2 && done_cyc <= TO + 1) begin
            rc = done_cyc + 1; xr = r_op; xe = 1'b0;
        end else begin
            rc = TO + 2; xr = '0; xe = 1'b1;
        end
        hs = rc + stall;
        obs_rc = -1;
        obs_start_cyc = -1;

        cyc = 0;
        req_valid = 1'b1;
        req_op = op; req_rs0 = rs0; req_rs1 = rs1; req_rd = rd;
        for (int u = 0; u < NU; u++)
            unit_result[32*u +: 32] = (legal && u == 32'(op)) ? r_op : $urandom;
        unit_done = '0;
        rsp_ready = 1'(($urandom) % 2);
        e_ready = 1'b1; e_valid = 1'b0; e_busy = 1'b0; e_start = '0;
        e_res = xr; e_err = xe;
        e_rs0 = prev_rs0; e_rs1 = prev_rs1; e_rd = prev_rd;
        chk_en = 1'b1;
        @(posedge clk); #1;
        e_rs0 = rs0; e_rs1 = rs1; e_rd = rd;
        for (int c = 1; c <= hs + 1; c++) begin
            cyc = c;
            e_busy  = (c <= hs);
            e_ready = !e_busy;
            e_valid = (c >= rc) && (c <= hs);
            e_start = (c == 1) ? oh : '0;
            req_valid = (c <= hs) ? 1'(($urandom) % 2) : 1'b0;
            req_op = OW'($urandom); req_rs0 = $urandom;
            req_rs1 = $urandom; req_rd = $urandom;
            unit_done = noise ? (NU'($urandom) & ~oh) : '0;
            if (legal && c == done_cyc) unit_done[op] = 1'b1;
            if (c < rc) rsp_ready = 1'(($urandom) % 2);
            else rsp_ready = (c == hs);
            @(posedge clk); #1;
        end
        unit_done = '0;
        rsp_ready = 1'b0;
        prev_rs0 = rs0; prev_rs1 = rs1; prev_rd = rd;
    endtask

    initial begin
        int seen;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(unit_start), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rs0", unit_rs0, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // unit0 returns 4, done in cycle 3
        run_txn(2'd0, 32'hF000_0000, 32'd31, 32'd7, 3, 0, 1'b0, 32'd4);
        chk("pin_op0_rsp_cyc", 32'(obs_rc), 32'd4);
        chk("pin_op0_start_cyc", 32'(obs_start_cyc), 32'd1);
        chk("pin_op0_result", obs_res, 32'd4);
        chk("pin_op0_err", 32'(obs_err), 32'd0);

        // response held off for five cycles
        run_txn(2'd1, 32'h1234, 32'h5678, 32'h9, 4, 5, 1'b0, 32'hCAFE_0001);
        chk("pin_op1_rsp_cyc", 32'(obs_rc), 32'd5);
        chk("pin_op1_result", obs_res, 32'hCAFE_0001);

        // illegal opcode
        run_txn(2'd3, 32'h1, 32'h2, 32'h3, 2, 1, 1'b1, 32'hDEAD);
        chk("pin_ill_rsp_cyc", 32'(obs_rc), 32'd1);
        chk("pin_ill_err", 32'(obs_err), 32'd1);
        chk("pin_ill_result", obs_res, 32'd0);
        chk("pin_ill_start", 32'(obs_start_cyc), 32'hFFFF_FFFF);

        // timeout, then a late done from unit2 during RESP
        run_txn(2'd2, 32'hA, 32'hB, 32'hC, TO + 3, 2, 1'b0, 32'hBEEF);
        chk("pin_to_rsp_cyc", 32'(obs_rc), 32'd10);
        chk("pin_to_err", 32'(obs_err), 32'd1);
        chk("pin_to_result", obs_res, 32'd0);
        run_txn(2'd0, 32'h3, 32'h4, 32'h5, 2, 0, 1'b0, 32'h77);
        chk("pin_after_to_rsp_cyc", 32'(obs_rc), 32'd3);

        // foreign done noise, own done in cycle 5
        run_txn(2'd0, 32'h11, 32'h22, 32'h33, 5, 0, 1'b1, 32'h4444);
        chk("pin_noise_rsp_cyc", 32'(obs_rc), 32'd6);
        chk("pin_noise_result", obs_res, 32'h4444);

        // done and timeout in the same cycle: done wins
        run_txn(2'd1, 32'h5, 32'h6, 32'h7, TO + 1, 0, 1'b1, 32'h5151);
        chk("pin_edge_rsp_cyc", 32'(obs_rc), 32'd10);
        chk("pin_edge_err", 32'(obs_err), 32'd0);

        // done during START is not seen
        run_txn(2'd2, 32'h8, 32'h9, 32'hA, 1, 0, 1'b0, 32'h6262);
        chk("pin_start_done_err", 32'(obs_err), 32'd1);

        for (int i = 0; i < 40; i++) begin
            run_txn(OW'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(1, TO + 3)), int'($urandom % 4),
                    1'(($urandom) % 2), $urandom);
        end

        // reset while in WAIT
        chk_en = 1'b0;
        req_valid = 1'b1; req_op = 2'd1;
        req_rs0 = 32'hAAAA; req_rs1 = 32'hBBBB; req_rd = 32'hCCCC;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rs0", unit_rs0, 32'd0);
        chk("mid_rst_start", 32'(unit_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        unit_done = '1;
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        unit_done = '0;
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        prev_rs0 = '0; prev_rs1 = '0; prev_rd = '0;
        run_txn(2'd1, 32'h42, 32'h43, 32'h44, 3, 1, 1'b1, 32'h9999);
        chk("pin_post_rst_rsp_cyc", 32'(obs_rc), 32'd4);
        chk("pin_post_rst_result", obs_res, 32'h9999);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/custom_unit_sequencer.md
Name: custom_unit_sequencer

Overview:
- Sequences the multi-cycle custom-instruction units (bit-count unit and siblings) on behalf of the core's custom-instruction issue path.
- Accepts one request at a time over a valid/ready handshake and decodes the opcode to one unit.
- Pulses that unit's start, holds operands stable for the whole operation, and waits for that unit's done.
- Returns the result over a second valid/ready handshake, with timeout and illegal-opcode error reporting.

Parameters:
NUM_UNITS, 4, number of attached custom units; unit index = opcode.
OP_W, 2, opcode width; must satisfy 2**OP_W >= NUM_UNITS.
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before an error response; range 2..1023.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_ni  in  1  asynchronous reset, active low.
req_valid_i  in  1  core issues a request.
req_ready_o  out  1  sequencer can accept a request.
req_op_i  in  OP_W  target unit index.
req_rs0_i  in  32  operand 0.
req_rs1_i  in  32  operand 1.
req_rd_i  in  32  current rd value (passed through to the unit).
rsp_valid_o  out  1  response available.
rsp_ready_i  in  1  core accepts the response.
rsp_result_o  out  32  unit result; 0 on error.
rsp_err_o  out  1  1 = timeout or illegal opcode.
unit_start_o  out  NUM_UNITS  one-hot start pulse.
unit_rs0_o  out  32  registered operand 0, shared by all units.
unit_rs1_o  out  32  registered operand 1.
unit_rd_o  out  32  registered rd.
unit_done_i  in  NUM_UNITS  per-unit done.
unit_result_i  in  NUM_UNITS*32  per-unit result; unit u occupies bits [32u+31:32u].
busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_ni=0) values:
  - state = IDLE.
  - req_ready_o = 1; rsp_valid_o = 0; rsp_err_o = 0.
  - rsp_result_o = 0; unit_start_o = 0; unit_rs0/rs1/rd_o = 0.
  - Timeout counter = 0; busy_o = 0.
  - Reset mid-operation abandons the transaction: no response is produced, and the unit is not notified.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - req_ready_o = 1; no other state asserts req_ready_o.
  - On req_valid_i && req_ready_o, latch op, rs0, rs1 and rd.
  - If op < NUM_UNITS, go to START.
  - Otherwise go to RESP with err = 1 and result = 0.
- START (exactly one cycle):
  - unit_start_o[op] = 1; all other bits 0.
  - Clear the timeout counter and go to WAIT.
  - unit_done_i is ignored in this cycle.
- WAIT:
  - unit_start_o = 0; the counter increments each cycle.
  - If unit_done_i[op] = 1: capture unit_result_i slice op into rsp_result_o, set err = 0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: set result = 0 and err = 1, go to RESP.
  - Done and timeout in the same cycle: done wins.
  - Done bits from non-selected units are ignored in every state.
- RESP:
  - rsp_valid_o = 1, with rsp_result_o and rsp_err_o stable while rsp_ready_i = 0.
  - On rsp_ready_i, go to IDLE and deassert rsp_valid_o the next cycle.
  - A new request is accepted no earlier than the cycle after the response handshake.
- unit_rs0/rs1/rd_o hold the latched values from acceptance until the next acceptance; units may sample them on any cycle.
- Latency (request accepted at edge 0):
  - start pulse in cycle 1.
  - A unit raising done in cycle k (k >= 2) gives rsp_valid_o in cycle k+1.
  - Illegal opcode gives rsp_valid_o in cycle 1.
  - Timeout gives rsp_valid_o in cycle TIMEOUT_CYCLES+2.
- Units must tolerate start being a single-cycle pulse.
- A unit that asserts done after a timeout is ignored; the sequencer does not track it.

Test Plan:
- Op=0, rs0=32'hF0000000, rs1=31; unit0 model returns 4 with done at cycle 3 -> start[0] high only in cycle 1; rsp_valid cycle 4, result=4, err=0; busy 1 in cycles 1-4.
- Op=1, with rsp_ready_i held low 5 cycles after rsp_valid -> result/err stable all 5 cycles; req_ready_o=0 throughout; IDLE returns after the handshake.
- Op=3 with NUM_UNITS=3 -> no start bit ever set; rsp_valid cycle 1, err=1, result=0.
- Op=2 with unit2 never done, TIMEOUT_CYCLES=8 -> rsp_valid cycle 10, err=1, result=0; a later done from unit2 is ignored; the next request for op=0 completes normally.
- Op=0 with done_i[1] pulsed in WAIT, then done_i[0] at cycle 5 -> result taken from slice 0; response cycle 6.
- Reset asserted during WAIT -> all outputs at reset values immediately; no response after release; a fresh request works.
